ahb_write_buffer: RTL
=====================

AHB_WRITE_BUFFER -- requirements
Module: ahb_write_buffer

Interface
REQ-001 SHALL have parameter W_ADDR, default 32, address width.
REQ-002 SHALL have parameter W_DATA, default 32, data width.
REQ-003 SHALL have parameter DEPTH, default 4, posted-write entries, power of 2, >=2.
REQ-004 SHALL have ports: clk input 1, the single clock; rst input 1, reset, synchronous and active-high.
REQ-005 SHALL have upstream AHB-Lite slave ports: src_hready_resp out 1, src_hready in 1, src_hresp out 1, src_haddr in W_ADDR, src_hwrite in 1, src_htrans in 2, src_hsize in 3, src_hburst in 3, src_hprot in 4, src_hmastlock in 1, src_hwdata in W_DATA, src_hrdata out W_DATA.
REQ-006 SHALL have downstream AHB-Lite master ports: dst_hready in 1, dst_hresp in 1, dst_haddr out W_ADDR, dst_hwrite out 1, dst_htrans out 2, dst_hsize out 3, dst_hburst out 3, dst_hprot out 4, dst_hmastlock out 1, dst_hwdata out W_DATA, dst_hrdata in W_DATA.
REQ-007 SHALL have ports: wbuf_err out 1, sticky posted-write error; wbuf_err_clr in 1, clears wbuf_err.

Function
REQ-008 SHALL hold a FIFO of DEPTH entries {addr, size, prot, wdata}; count width $clog2(DEPTH)+1, pointers wrap modulo DEPTH.
REQ-009 SHALL capture an upstream write address phase (src_hready & src_htrans[1] & src_hwrite) and complete its data phase with zero wait states if an entry is free, pushing src_hwdata at that data-phase end.
REQ-010 SHALL, when the FIFO is full at a write data phase, hold src_hready_resp low until a downstream write completes, then push on that cycle.
REQ-011 SHALL stall an upstream read data phase (src_hready_resp low) until FIFO empty and no downstream write in flight, then issue it downstream as NONSEQ SINGLE with captured attributes, returning dst_hrdata and dst_hready/dst_hresp on src.
REQ-012 SHALL drain the FIFO head as downstream NONSEQ SINGLE writes, hwdata driven in the following data phase, one entry popped per dst_hready-completed data phase; back-to-back drains pipelined.
REQ-013 SHALL use states IDLE, WRITE (drain active), READ (read forwarded); IDLE->WRITE on FIFO non-empty; WRITE->IDLE on last pop; IDLE->READ only when FIFO empty; READ->IDLE on dst data-phase completion.
REQ-014 SHALL give pending writes priority over a pending read (read-after-write ordering preserved).
REQ-015 SHALL allow push and pop in the same cycle with count unchanged, including when full.
REQ-016 SHALL drive src_hresp OKAY for all writes; read errors pass through with the two-cycle AHB error response.
REQ-017 SHALL drive dst_htrans IDLE, dst_hmastlock 0, dst_hburst SINGLE whenever not issuing.
REQ-018 SHALL treat upstream IDLE/BUSY as no-op with zero-wait OKAY.

Reset
REQ-019 SHALL on rst: empty FIFO, state IDLE, src_hready_resp 1, src_hresp 0, dst_htrans 0, dst_haddr 0, dst_hwrite 0, wbuf_err 0.
REQ-020 SHALL discard buffered and in-flight transfers when rst asserts mid-operation; no write issued after reset.

Configuration
REQ-021 SHALL, with WRITE_BUFFER_ERR_EN defined, set wbuf_err on any downstream write error response, clear it on wbuf_err_clr (set wins on same cycle), and still pop the entry.
REQ-022 SHALL, without WRITE_BUFFER_ERR_EN, tie wbuf_err to 0 and ignore write errors.

Structure
REQ-023 SHALL place HTRANS/HBURST/HSIZE encodings and state encodings in the shared package ahb_pkg.
REQ-024 SHALL implement storage as sub-module sync_fifo (WIDTH, DEPTH parameters, push/pop/full/empty/level).

Verification
REQ-025 SHALL cover: single write 0x10<-0xA5A5A5A5 -> zero-wait upstream, dst write appears next cycle, SRAM reads back 0xA5A5A5A5.
REQ-026 SHALL cover: 6 back-to-back writes, DEPTH=4, dst_hready held low -> 5th write data phase stalls until first dst completion; all 6 land in order.
REQ-027 SHALL cover: write 0x20<-1 then immediate read 0x20 -> read stalls until drain, returns 1.
REQ-028 SHALL cover: dst write error with WRITE_BUFFER_ERR_EN -> wbuf_err=1 until wbuf_err_clr pulse; src_hresp stays 0.
REQ-029 SHALL cover: rst pulsed with 3 entries buffered -> dst_htrans 0 next cycle, no further writes, count 0.
REQ-030 SHALL cover: 10000-cycle random read/write mix against SRAM model and shadow array -> every read matches shadow, no X on src_hrdata.

Source files
------------

// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Package : ahb_pkg
// Brief   : AHB-Lite encodings and write-buffer state encoding.
// Rev     : 1.0  initial release
// ============================================================================
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : sync_fifo
// Brief  : Synchronous FIFO with head and head+1 read ports and a level count.
// Rev    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [WIDTH-1:0]         o_rdata_nxt,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full      = (r_level == (AW+1)'(DEPTH));
    assign o_empty     = (r_level == '0);
    assign o_level     = r_level;
    assign w_do_pop    = i_pop & ~o_empty;
    // A pop frees the slot this cycle, so a full FIFO still accepts the push.
    assign w_do_push   = i_push & (~o_full | w_do_pop);
    assign o_rdata     = r_mem[r_rptr];
    assign o_rdata_nxt = r_mem[r_rptr + AW'(1)];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/ahb_write_buffer.sv
`default_nettype none
// ============================================================================
// Module : ahb_write_buffer
// Brief  : AHB-Lite posted-write buffer; reads wait for the buffer to drain.
//          Define WRITE_BUFFER_ERR_EN to record downstream write errors.
// Rev    : 1.0  initial release
// ============================================================================
module ahb_write_buffer
    import ahb_pkg::*;
#(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              src_hready_resp,
    input  logic              src_hready,
    output logic              src_hresp,
    input  logic [W_ADDR-1:0] src_haddr,
    input  logic              src_hwrite,
    input  logic [1:0]        src_htrans,
    input  logic [2:0]        src_hsize,
    input  logic [2:0]        src_hburst,
    input  logic [3:0]        src_hprot,
    input  logic              src_hmastlock,
    input  logic [W_DATA-1:0] src_hwdata,
    output logic [W_DATA-1:0] src_hrdata,
    input  logic              dst_hready,
    input  logic              dst_hresp,
    output logic [W_ADDR-1:0] dst_haddr,
    output logic              dst_hwrite,
    output logic [1:0]        dst_htrans,
    output logic [2:0]        dst_hsize,
    output logic [2:0]        dst_hburst,
    output logic [3:0]        dst_hprot,
    output logic              dst_hmastlock,
    output logic [W_DATA-1:0] dst_hwdata,
    input  logic [W_DATA-1:0] dst_hrdata,
    output logic              wbuf_err,
    input  logic              wbuf_err_clr
);
    localparam int W_ENT = W_ADDR + 3 + 4 + W_DATA;
    localparam int LW    = $clog2(DEPTH) + 1;

    wb_state_t         r_state;
    logic              r_wr_dp;
    logic              r_rd_pend;
    logic              r_dp_wr;
    logic [W_ADDR-1:0] r_src_addr;
    logic [2:0]        r_src_size;
    logic [3:0]        r_src_prot;
    logic              r_src_lock;

    logic [W_ENT-1:0]  w_head;
    logic [W_ENT-1:0]  w_nxt;
    logic [W_ENT-1:0]  w_iss_ent;
    logic              w_full;
    logic              w_empty;
    logic [LW-1:0]     w_level;
    logic              w_push;
    logic              w_pop;
    logic              w_issue_wr;
    logic              w_issue_rd;

    assign w_pop  = r_dp_wr & dst_hready;
    assign w_push = r_wr_dp & (~w_full | w_pop);

    sync_fifo #(
        .WIDTH (W_ENT),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_wdata     ({r_src_addr, r_src_size, r_src_prot, src_hwdata}),
        .i_pop       (w_pop),
        .o_rdata     (w_head),
        .o_rdata_nxt (w_nxt),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (w_level)
    );

    // The in-flight data phase always belongs to the FIFO head, so the next
    // address phase comes from head+1 whenever a write data phase is open.
    assign w_issue_wr = (r_state != ST_READ) & (w_level > LW'(r_dp_wr));
    assign w_issue_rd = (r_state == ST_IDLE) & r_rd_pend & w_empty & ~r_dp_wr;
    assign w_iss_ent  = r_dp_wr ? w_nxt : w_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_dp    <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_src_addr <= '0;
            r_src_size <= '0;
            r_src_prot <= '0;
            r_src_lock <= 1'b0;
        end else if (src_hready) begin
            r_wr_dp    <= src_htrans[1] & src_hwrite;
            r_rd_pend  <= src_htrans[1] & ~src_hwrite;
            r_src_addr <= src_haddr;
            r_src_size <= src_hsize;
            r_src_prot <= src_hprot;
            r_src_lock <= src_hmastlock;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_dp_wr <= 1'b0;
        end else begin
            if (dst_hready) r_dp_wr <= w_issue_wr;
            case (r_state)
                ST_IDLE: begin
                    if (w_issue_rd & dst_hready) r_state <= ST_READ;
                    else if (~w_empty)           r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (w_pop & ~w_push & (w_level == LW'(1))) r_state <= ST_IDLE;
                end
                ST_READ: begin
                    if (dst_hready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dst_htrans    = HTRANS_IDLE;
        dst_haddr     = '0;
        dst_hwrite    = 1'b0;
        dst_hsize     = '0;
        dst_hprot     = '0;
        dst_hburst    = HBURST_SINGLE;
        dst_hmastlock = 1'b0;
        if (w_issue_wr) begin
            dst_htrans = HTRANS_NONSEQ;
            dst_haddr  = w_iss_ent[W_ENT-1 -: W_ADDR];
            dst_hwrite = 1'b1;
            dst_hsize  = w_iss_ent[W_DATA+4 +: 3];
            dst_hprot  = w_iss_ent[W_DATA +: 4];
        end else if (w_issue_rd) begin
            dst_htrans    = HTRANS_NONSEQ;
            dst_haddr     = r_src_addr;
            dst_hsize     = r_src_size;
            dst_hprot     = r_src_prot;
            dst_hmastlock = r_src_lock;
        end
    end

    assign dst_hwdata = r_dp_wr ? w_head[W_DATA-1:0] : '0;

    always_comb begin
        src_hready_resp = 1'b1;
        src_hresp       = 1'b0;
        src_hrdata      = '0;
        if (r_wr_dp) begin
            src_hready_resp = ~w_full | w_pop;
        end else if (r_rd_pend) begin
            src_hready_resp = 1'b0;
            if (r_state == ST_READ) begin
                src_hready_resp = dst_hready;
                src_hresp       = dst_hresp;
                src_hrdata      = dst_hrdata;
            end
        end
    end

`ifdef WRITE_BUFFER_ERR_EN
    logic r_err;
    logic w_unused;

    always_ff @(posedge clk) begin
        if (rst)                       r_err <= 1'b0;
        else if (r_dp_wr & dst_hresp)  r_err <= 1'b1;
        else if (wbuf_err_clr)         r_err <= 1'b0;
    end

    assign wbuf_err = r_err;
    assign w_unused = ^{src_hburst, src_htrans[0], w_nxt[W_DATA-1:0]};
`else
    logic w_unused;

    assign wbuf_err = 1'b0;
    assign w_unused = ^{src_hburst, src_htrans[0], w_nxt[W_DATA-1:0], wbuf_err_clr};
`endif

endmodule
`default_nettype wire
